// File: rtl/sle_vec_if.sv
// Bus interface for sle_vec: control, data and registered outputs.
// Optional macro SLE_VEC_PARITY_EN adds the PAR output signal.
interface sle_vec_if #(
  parameter int unsigned WIDTH = 8
);
  logic             EN;
  logic             SLn;
  logic [WIDTH-1:0] SD;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             SI;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic             TC;
`ifdef SLE_VEC_PARITY_EN
  logic             PAR;
`endif

  // Driver side: issues controls and data, observes the register.
  modport master (
    output EN, SLn, SD, MODE, D, SI,
`ifdef SLE_VEC_PARITY_EN
    input  PAR,
`endif
    input  Q, SO, TC
  );

  // Register side: consumes controls and data, presents the state.
  modport slave (
    input  EN, SLn, SD, MODE, D, SI,
`ifdef SLE_VEC_PARITY_EN
    output PAR,
`endif
    output Q, SO, TC
  );
endinterface

// File: rtl/sle_vec.sv
// sle_vec: loadable shift-left/shift-right/up-count register with
// synchronous load, shift-out bit and terminal-count pulse.
// Optional macro SLE_VEC_PARITY_EN adds registered parity of Q on PAR.
module sle_vec #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic     CLK,
  input  logic     RSTn,
  sle_vec_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_CNT  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic             tc_q, tc_d;
  mode_e            mode;

  assign mode = mode_e'(bus.MODE);

  // Next state: SLn load beats the enabled MODE operation; TC only survives a wrap.
  always_comb begin
    q_d  = q_q;
    so_d = so_q;
    tc_d = 1'b0;
    if (!bus.SLn) begin
      q_d = bus.SD;
    end else if (bus.EN) begin
      case (mode)
        MODE_LOAD: q_d = bus.D;
        MODE_SHL: begin
          q_d  = {q_q[WIDTH-2:0], bus.SI};
          so_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d  = {bus.SI, q_q[WIDTH-1:1]};
          so_d = q_q[0];
        end
        MODE_CNT: begin
          q_d  = q_q + WIDTH'(1);
          tc_d = &q_q;
        end
        default: q_d = q_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      q_q  <= INIT;
      so_q <= 1'b0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
      tc_q <= tc_d;
    end
  end

  assign bus.Q  = q_q;
  assign bus.SO = so_q;
  assign bus.TC = tc_q;

`ifdef SLE_VEC_PARITY_EN
  logic par_q, par_d;

  // Parity follows whatever value Q is about to take.
  always_comb begin
    par_d = ^q_d;
  end

  // Parity register; forced to 0 on reset regardless of INIT.
  always_ff @(posedge CLK) begin
    if (!RSTn) par_q <= 1'b0;
    else       par_q <= par_d;
  end

  assign bus.PAR = par_q;
`endif

endmodule

// File: tb/tb_sle_vec.sv
// Scoreboard bench for sle_vec (WIDTH=8, INIT=0); optional SLE_VEC_PARITY_EN checks PAR.
module tb_sle_vec;

  typedef struct {
    logic [7:0] q;
    logic       so;
    logic       tc;
    logic       par;
    string      name;
  } exp_t;

  logic clk;
  logic rstn;
  exp_t sb[$];
  int   checks;
  int   passes;
  bit   stim_done;

  sle_vec_if #(.WIDTH(8)) bus ();

  sle_vec #(.WIDTH(8), .INIT(8'h00)) dut (
    .CLK  (clk),
    .RSTn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Apply one cycle of inputs at the falling edge and queue the post-edge expectation.
  task automatic step(input string name, input logic r, input logic sln, input logic [7:0] sd,
                      input logic en, input logic [1:0] mode, input logic [7:0] d, input logic si,
                      input logic [7:0] eq, input logic eso, input logic etc);
    exp_t e;
    @(negedge clk);
    rstn     = r;
    bus.SLn  = sln;
    bus.SD   = sd;
    bus.EN   = en;
    bus.MODE = mode;
    bus.D    = d;
    bus.SI   = si;
    e.q    = eq;
    e.so   = eso;
    e.tc   = etc;
    e.par  = r ? ^eq : 1'b0;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: after every rising edge, compare against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".q"},  32'(bus.Q),  32'(e.q));
        check({e.name, ".so"}, 32'(bus.SO), 32'(e.so));
        check({e.name, ".tc"}, 32'(bus.TC), 32'(e.tc));
`ifdef SLE_VEC_PARITY_EN
        check({e.name, ".par"}, 32'(bus.PAR), 32'(e.par));
`endif
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    stim_done = 1'b0;
    checks    = 0;
    passes    = 0;
    rstn      = 1'b0;
    bus.SLn   = 1'b0;
    bus.SD    = 8'hFF;
    bus.EN    = 1'b1;
    bus.MODE  = 2'b11;
    bus.D     = 8'h00;
    bus.SI    = 1'b0;

    // Reset overrides SLn load
    step("rst0", 0, 0, 8'hFF, 1, 2'b11, 8'h00, 0, 8'h00, 0, 0);
    step("rst1", 0, 0, 8'hFF, 1, 2'b11, 8'h00, 0, 8'h00, 0, 0);
    // SLn load ignores EN/MODE, then hold
    step("sl_a5", 1, 0, 8'hA5, 0, 2'b11, 8'h00, 0, 8'hA5, 0, 0);
    for (int i = 0; i < 5; i++)
      step("hold_a5", 1, 1, 8'h00, 0, 2'b11, 8'h3C, 1, 8'hA5, 0, 0);
    // Parallel load and shifts
    step("ld_81", 1, 1, 8'h00, 1, 2'b00, 8'h81, 0, 8'h81, 0, 0);
    step("shl1",  1, 1, 8'h00, 1, 2'b01, 8'h00, 0, 8'h02, 1, 0);
    step("shl2",  1, 1, 8'h00, 1, 2'b01, 8'h00, 0, 8'h04, 0, 0);
    step("shr1",  1, 1, 8'h00, 1, 2'b10, 8'h00, 1, 8'h82, 0, 0);
    step("shr2",  1, 1, 8'h00, 1, 2'b10, 8'h00, 0, 8'h41, 0, 0);
    step("shr3",  1, 1, 8'h00, 1, 2'b10, 8'h00, 0, 8'h20, 1, 0);
    // Load keeps SO; count through wrap
    step("ld_fe", 1, 1, 8'h00, 1, 2'b00, 8'hFE, 0, 8'hFE, 1, 0);
    step("cnt_ff", 1, 1, 8'h00, 1, 2'b11, 8'h00, 0, 8'hFF, 1, 0);
    step("cnt_00", 1, 1, 8'h00, 1, 2'b11, 8'h00, 0, 8'h00, 1, 1);
    step("cnt_01", 1, 1, 8'h00, 1, 2'b11, 8'h00, 0, 8'h01, 1, 0);
    // SLn beats enabled count; TC clears on EN low
    step("sl_ff",  1, 0, 8'hFF, 1, 2'b11, 8'h00, 0, 8'hFF, 1, 0);
    step("wrap2",  1, 1, 8'h00, 1, 2'b11, 8'h00, 0, 8'h00, 1, 1);
    step("en_off", 1, 1, 8'h00, 0, 2'b11, 8'h00, 0, 8'h00, 1, 0);
    // SLn at all-ones with count enabled: no TC
    step("sl_ff2", 1, 0, 8'hFF, 1, 2'b11, 8'h00, 0, 8'hFF, 1, 0);
    step("sl_12",  1, 0, 8'h12, 1, 2'b11, 8'h00, 0, 8'h12, 1, 0);
    step("shr_09", 1, 1, 8'h00, 1, 2'b10, 8'h00, 0, 8'h09, 0, 0);
    step("sl_80",  1, 0, 8'h80, 0, 2'b00, 8'h00, 0, 8'h80, 0, 0);
    step("shl_01", 1, 1, 8'h00, 1, 2'b01, 8'h00, 1, 8'h01, 1, 0);
    // Reset mid-count discards state
    step("sl_7e",  1, 0, 8'h7E, 1, 2'b00, 8'h00, 0, 8'h7E, 1, 0);
    step("cnt_7f", 1, 1, 8'h00, 1, 2'b11, 8'h00, 0, 8'h7F, 1, 0);
    step("rst_mid", 0, 0, 8'hAA, 1, 2'b11, 8'h00, 0, 8'h00, 0, 0);
    step("ld_07",  1, 1, 8'h00, 1, 2'b00, 8'h07, 0, 8'h07, 0, 0);
    // Reset while a wrap would occur: no residual TC
    step("sl_ff3", 1, 0, 8'hFF, 0, 2'b00, 8'h00, 0, 8'hFF, 0, 0);
    step("rst_wrap", 0, 1, 8'h00, 1, 2'b11, 8'h00, 0, 8'h00, 0, 0);
    step("post_rst", 1, 1, 8'h00, 0, 2'b11, 8'h00, 0, 8'h00, 0, 0);
    step("cnt_init", 1, 1, 8'h00, 1, 2'b11, 8'h00, 0, 8'h01, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sle_vec.md
SLE_VEC -- requirements
Module: sle_vec

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width in bits (legal range 2..32).
REQ-002 Parameter INIT, default 0, SHALL set the WIDTH-bit value Q takes on reset.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RSTn  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 EN  input  1  SHALL be the clock enable for the MODE operations.
REQ-006 SLn  input  1  SHALL be the active-low synchronous load of SD, independent of EN.
REQ-007 SD  input  WIDTH  SHALL be the synchronous-load data value.
REQ-008 MODE  input  2  SHALL select the operation: 00 load D, 01 shift left, 10 shift right, 11 count up.
REQ-009 D  input  WIDTH  SHALL be the parallel data loaded in MODE 00.
REQ-010 SI  input  1  SHALL be the serial input for both shift modes.
REQ-011 Q  output  WIDTH  SHALL be the registered state.
REQ-012 SO  output  1  SHALL be the shifted-out bit: registered, Q[WIDTH-1] for shift left, Q[0] for shift right.
REQ-013 TC  output  1  SHALL be the registered terminal-count pulse.

Function
REQ-014 Per rising CLK, priority SHALL be: RSTn low > SLn low > EN high with MODE > hold.
REQ-015 With SLn low, Q SHALL become SD on the next edge regardless of EN and MODE; SO holds; TC clears to 0.
REQ-016 With EN low and SLn high, Q, SO and TC SHALL hold, except TC, which clears to 0.
REQ-017 MODE 00 with EN high SHALL give Q <= D with 1-cycle latency; SO holds.
REQ-018 MODE 01 with EN high SHALL give Q <= {Q[WIDTH-2:0], SI} and SO <= old Q[WIDTH-1].
REQ-019 MODE 10 with EN high SHALL give Q <= {SI, Q[WIDTH-1:1]} and SO <= old Q[0].
REQ-020 MODE 11 with EN high SHALL give Q <= Q+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-021 TC SHALL be 1 for exactly the one cycle following an edge on which MODE 11 and EN were high and old Q was all-ones; otherwise 0.
REQ-022 A MODE change between cycles SHALL take effect on the next edge, with no pipeline bubble or extra latency.
REQ-023 Q SHALL hold any value, including INIT, indefinitely while EN is low and SLn is high.

Reset
REQ-024 RSTn low at a rising edge SHALL set Q=INIT, SO=0 and TC=0, overriding SLn, EN and MODE.
REQ-025 A reset asserted mid-count or mid-shift SHALL discard the operation in progress, with no residual TC or SO effect.
REQ-026 While RSTn is deasserted, outputs SHALL not change except at a rising CLK edge.

Configuration
REQ-027 With macro SLE_VEC_PARITY_EN defined, the block SHALL add output PAR (1 bit), registered, equal to the even parity (XOR-reduce) of the next Q; PAR SHALL be 0 after reset and SHALL track every Q update, including SLn loads.
REQ-028 Without SLE_VEC_PARITY_EN, the block SHALL have no PAR port and no parity logic.

Verification (WIDTH=8, INIT=8'h00)
REQ-029 RSTn=0 for 2 cycles with SLn=0, SD=8'hFF -> Q=8'h00, SO=0, TC=0.
REQ-030 SLn=0, SD=8'hA5, EN=0, MODE=11 -> Q=8'hA5 after 1 edge; with SLn=1, EN=0 -> Q holds 8'hA5 for 5 cycles.
REQ-031 Q=8'h81, MODE=01, EN=1, SI=0 for 2 edges -> Q=8'h02 then 8'h04, SO=1 then 0; then MODE=10, SI=1 -> Q=8'h82, SO=0.
REQ-032 Q=8'hFE, MODE=11, EN=1 for 3 edges -> Q=FF, 00, 01; TC=1 only in the cycle after the FF->00 edge.
REQ-033 Count at Q=8'h7F, RSTn=0 for 1 edge -> Q=8'h00, TC=0; with SLE_VEC_PARITY_EN and load D=8'h07 -> PAR=1.
